fsk_modulator: RTL and testbench
================================

// Module: fsk_modulator
// PURPOSE
//  Transmit-side stage feeding the FSK demodulator's 8-bit sample input. Accepts
//  a serial bit stream over a valid/ready handshake, buffers it in a small FIFO,
//  and emits one 8-bit triangle-wave sample per clk. Each bit occupies SYM_LEN
//  clocks at tone FTW1 (bit=1) or FTW0 (bit=0); phase is continuous (CPFSK).
// PARAMETERS
//  SYM_LEN     256      clocks per symbol; must equal the demodulator symbol window
//  PHASE_W     16       phase accumulator width, >= 9
//  FTW0        16'h0400 phase increment per clk for bit 0 (64-clk tone period)
//  FTW1        16'h1000 phase increment per clk for bit 1 (16-clk tone period)
//  FIFO_DEPTH  4        bit buffer entries, power of 2
//  IDLE_LEVEL  8'd0     mod_out value while idle
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  bit_in     in   1  data bit to transmit
//  bit_valid  in   1  bit_in valid; push occurs when bit_valid && bit_ready
//  bit_ready  out  1  = !fifo_full (combinational from registered count)
//  mod_out    out  8  registered modulated sample, to demodulator cin
//  busy       out  1  registered; 1 while state==SEND
//  tx_done    out  1  one-clk pulse when the last buffered symbol completes
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, phase=0, sym_cnt=0, cur_bit=0,
//   mod_out=IDLE_LEVEL, busy=0, tx_done=0; bit_ready=1.
//  FIFO: push on valid&&ready; pop only by FSM. Push+pop same cycle (not full):
//   both occur, count unchanged. When full, bit_ready=0 even if a pop occurs.
//  FSM states IDLE, SEND:
//   IDLE: mod_out<=IDLE_LEVEL, phase<=0. If FIFO non-empty (registered count):
//    pop to cur_bit, sym_cnt<=0, ->SEND.
//   SEND, every clk: mod_out<=tri(phase); phase<=phase+(cur_bit?FTW1:FTW0)
//    (mod PHASE_W wrap); sym_cnt<=sym_cnt+1.
//   SEND, sym_cnt==SYM_LEN-1: FIFO non-empty -> pop to cur_bit, sym_cnt<=0, stay
//    SEND, phase NOT reset. FIFO empty -> ->IDLE, tx_done<=1 for one clk,
//    phase<=0; mod_out=IDLE_LEVEL from the following edge.
//  tri(p): t=p[PHASE_W-2 -: 8]; tri = p[PHASE_W-1] ? ~t : t (8-bit, 0..255).
//  Latency: bit pushed at edge T from idle/empty -> IDLE pops at edge T+1
//   (busy=1) -> first sample tri(0)=0 on mod_out at edge T+2. Each symbol
//   drives exactly SYM_LEN samples.
//  Push arriving in the boundary cycle with FIFO empty is not seen: FSM goes
//   IDLE for one clk (tx_done pulses), then restarts with phase 0.
//  Back-to-back capacity: 1 symbol in flight + FIFO_DEPTH buffered.
//  rst asserted mid-SEND: immediate return to reset values; buffered bits lost.
// TESTING
//  1 rst pulse mid-SEND with 3 bits buffered -> same-cycle mod_out=0, busy=0,
//    bit_ready=1, tx_done=0; no further samples without new pushes.
//  2 push single '1' at T -> busy=1 at T+1; mod_out from T+2: 0,32,64..224,255,
//    223..31, repeat (period 16); 256 samples, then tx_done one clk, busy=0,
//    mod_out=0.
//  3 push '0' -> samples step 8: 0,8..248,255,247.. period 64; 256 samples.
//  4 hold bit_valid with 1,0,1,0,1,1 -> 5 accepted, bit_ready=0 until first
//    symbol boundary; symbols contiguous, 256 clks each, phase continuous
//    at each boundary (no return to 0), one tx_done after 6th symbol.
//  5 FIFO count 2, push and pop same cycle -> count stays 2, bit order kept.
//  6 push exactly at sym_cnt==255 with FIFO empty -> busy 0 for one clk,
//    tx_done pulse, then new symbol starting at sample 0.

Source files
------------

// File: rtl/fsk_modulator.sv
// Continuous-phase FSK modulator.
// Serial bits arrive over a valid/ready handshake into a small FIFO; each bit is sent as
// SYM_LEN 8-bit triangle-wave samples at tone FTW1 (bit 1) or FTW0 (bit 0). The phase
// accumulator carries across back-to-back symbols and is cleared only when the
// transmitter goes idle.
module fsk_modulator #(
    parameter int unsigned        SYM_LEN    = 256,
    parameter int unsigned        PHASE_W    = 16,
    parameter logic [PHASE_W-1:0] FTW0       = 'h0400,
    parameter logic [PHASE_W-1:0] FTW1       = 'h1000,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [7:0]         IDLE_LEVEL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [7:0] mod_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned SymW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [SymW-1:0] SymLast = SymW'(SYM_LEN - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // FIFO storage and bookkeeping
    logic [FIFO_DEPTH-1:0] fifo_mem_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       fifo_cnt_q;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_head;

    // Transmit state
    state_e                state_q;
    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_step;
    logic [SymW-1:0]       sym_cnt_q;
    logic                  cur_bit_q;
    logic [7:0]            mod_out_q;
    logic                  busy_q;
    logic                  tx_done_q;

    // Wrap-around pointer increment, valid for any depth
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    // Triangle shaping: rising ramp in the lower half-cycle, mirrored in the upper half
    function automatic logic [7:0] tri_wave(input logic [PHASE_W-1:0] p);
        logic [7:0] t;
        t = p[PHASE_W-2 -: 8];
        return p[PHASE_W-1] ? ~t : t;
    endfunction

    // Handshake, pop decision and tone selection, all from registered state
    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        bit_ready  = (fifo_cnt_q != CntFull);
        fifo_push  = bit_valid && bit_ready;
        fifo_head  = fifo_mem_q[rd_ptr_q];
        // Pop when idle, or at the last clock of the current symbol
        fifo_pop   = !fifo_empty && ((state_q == StIdle) || (sym_cnt_q == SymLast));
        phase_step = cur_bit_q ? FTW1 : FTW0;
    end

    // Bit FIFO; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem_q[wr_ptr_q] <= bit_in;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Symbol sequencer with registered sample, busy and done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            sym_cnt_q <= '0;
            cur_bit_q <= 1'b0;
            mod_out_q <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    mod_out_q <= IDLE_LEVEL;
                    phase_q   <= '0;
                    if (fifo_pop) begin
                        cur_bit_q <= fifo_head;
                        sym_cnt_q <= '0;
                        state_q   <= StSend;
                        busy_q    <= 1'b1;
                    end
                end
                StSend: begin
                    mod_out_q <= tri_wave(phase_q);
                    phase_q   <= phase_q + phase_step;
                    if (sym_cnt_q == SymLast) begin
                        if (fifo_pop) begin
                            // Next symbol follows directly; phase keeps running
                            cur_bit_q <= fifo_head;
                            sym_cnt_q <= '0;
                        end else begin
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                            tx_done_q <= 1'b1;
                            phase_q   <= '0;
                        end
                    end else begin
                        sym_cnt_q <= sym_cnt_q + SymW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mod_out = mod_out_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// Bench for fsk_modulator: directed scenarios plus random bursts, every clock compared
// against a transaction-level model (bit queue, integer phase, arithmetic triangle).
module tb_fsk_modulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [7:0] mod_out;
    logic       busy;
    logic       tx_done;

    always #5 clk = ~clk;

    fsk_modulator dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .mod_out   (mod_out),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_q[$];
    bit m_send;
    int m_phase;
    int m_cnt;
    bit m_bit;
    int m_out;
    bit m_busy;
    bit m_done;
    bit m_accept;
    logic last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tri_ref(input int p);
        int t;
        t = (p / 128) % 256;
        return (p >= 32768) ? 255 - t : t;
    endfunction

    // Expected k-th sample of an isolated symbol, from the tone shape alone
    function automatic int tone1(input int k);
        int pos;
        pos = k % 16;
        return (pos < 8) ? 32 * pos : 255 - 32 * (pos - 8);
    endfunction

    function automatic int tone0(input int k);
        int pos;
        pos = k % 64;
        return (pos < 32) ? 8 * pos : 255 - 8 * (pos - 32);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_send = 0; m_phase = 0; m_cnt = 0; m_bit = 0;
        m_out = 0; m_busy = 0; m_done = 0; m_accept = 0;
    endtask

    task automatic model_edge(input logic v, input logic b);
        int sz;
        sz = m_q.size();
        m_accept = v && (sz < 4);
        m_done = 0;
        if (!m_send) begin
            m_out = 0;
            m_phase = 0;
            if (sz > 0) begin
                m_bit = m_q.pop_front();
                m_cnt = 0;
                m_send = 1;
                m_busy = 1;
            end
        end else begin
            m_out = tri_ref(m_phase);
            m_phase = (m_phase + (m_bit ? 4096 : 1024)) % 65536;
            if (m_cnt == 255) begin
                if (sz > 0) begin
                    m_bit = m_q.pop_front();
                    m_cnt = 0;
                end else begin
                    m_send = 0;
                    m_busy = 0;
                    m_done = 1;
                    m_phase = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        if (m_accept) m_q.push_back(b);
    endtask

    task automatic check_all();
        chk("mod_out", {24'd0, mod_out}, m_out);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("tx_done", {31'd0, tx_done}, {31'd0, m_done});
        chk("bit_ready", {31'd0, bit_ready}, (m_q.size() < 4) ? 1 : 0);
    endtask

    task automatic step(input logic v, input logic b);
        bit_valid = v;
        bit_in = b;
        last_ready = bit_ready;
        @(posedge clk);
        model_edge(v, b);
        #1;
        check_all();
    endtask

    task automatic drain(output int pulses);
        int n;
        n = 0;
        pulses = 0;
        while ((m_send || m_q.size() > 0) && n < 5000) begin
            step(0, 0);
            pulses += tx_done;
            n++;
        end
        chk("drain_bound", (n < 5000) ? 1 : 0, 1);
        step(0, 0);
    endtask

    task automatic wait_boundary(input string tag, input bit need_empty);
        int n;
        n = 0;
        while (!(m_send && m_cnt == 255 && (!need_empty || m_q.size() == 0)) && n < 2000) begin
            step(0, 0);
            n++;
        end
        chk(tag, (n < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        int pulses;
        int acc;
        int n;
        int seq[6];

        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_mod_out", {24'd0, mod_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tx_done", {31'd0, tx_done}, 0);
        chk("rst_bit_ready", {31'd0, bit_ready}, 1);
        #5 rst = 1'b0;

        // Single '1': busy one clk after push, 256 samples of the 16-clk tone
        step(1, 1);
        step(0, 0);
        chk("t2_busy_T1", {31'd0, busy}, 1);
        for (int k = 0; k < 256; k++) begin
            step(0, 0);
            chk("t2_tone1", {24'd0, mod_out}, tone1(k));
        end
        chk("t2_done", {31'd0, tx_done}, 1);
        chk("t2_busy_end", {31'd0, busy}, 0);
        step(0, 0);
        chk("t2_idle_level", {24'd0, mod_out}, 0);
        chk("t2_done_clear", {31'd0, tx_done}, 0);

        // Single '0': 64-clk tone
        step(1, 0);
        step(0, 0);
        for (int k = 0; k < 256; k++) begin
            step(0, 0);
            chk("t3_tone0", {24'd0, mod_out}, tone0(k));
        end
        chk("t3_done", {31'd0, tx_done}, 1);
        step(0, 0);

        // Held valid with 1,0,1,0,1,1: five accepted before the first boundary
        seq = '{1, 0, 1, 0, 1, 1};
        acc = 0; n = 0; pulses = 0;
        while (acc < 6 && n < 2000) begin
            step(1, seq[acc][0]);
            if (n < 10 && last_ready === 1'b1) begin
                if (acc == 4) chk("t4_early_count", acc + 1, 5);
            end
            if (n == 9) chk("t4_ready_low", {31'd0, bit_ready}, 0);
            if (last_ready === 1'b1) acc++;
            pulses += tx_done;
            n++;
        end
        chk("t4_all_accepted", acc, 6);
        drain(n);
        chk("t4_done_pulses", pulses + n, 1);

        // Count 2 with push and pop in the same boundary cycle
        step(1, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(1, 1);
        wait_boundary("t5_reach_boundary", 0);
        step(1, 0);
        chk("t5_push_at_pop", {31'd0, last_ready}, 1);
        chk("t5_busy_kept", {31'd0, busy}, 1);
        drain(pulses);
        chk("t5_done_pulses", pulses, 1);

        // Push landing on the boundary cycle with the FIFO empty
        step(1, 1);
        wait_boundary("t6_reach_boundary", 1);
        step(1, 1);
        chk("t6_done", {31'd0, tx_done}, 1);
        chk("t6_busy_gap", {31'd0, busy}, 0);
        step(0, 0);
        chk("t6_busy_again", {31'd0, busy}, 1);
        chk("t6_done_clear", {31'd0, tx_done}, 0);
        chk("t6_idle_sample", {24'd0, mod_out}, 0);
        step(0, 0);
        chk("t6_first_sample", {24'd0, mod_out}, 0);
        step(0, 0);
        chk("t6_second_sample", {24'd0, mod_out}, 32);
        drain(pulses);

        // Reset mid-symbol with three bits buffered
        step(1, 1);
        step(1, 0);
        step(1, 1);
        step(1, 1);
        for (int k = 0; k < 20; k++) step(0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t1_mod_out", {24'd0, mod_out}, 0);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_bit_ready", {31'd0, bit_ready}, 1);
        chk("t1_tx_done", {31'd0, tx_done}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            step(0, 0);
            pulses += busy;
        end
        chk("t1_stays_idle", pulses, 0);

        // Random bursts separated by random gaps
        for (int burst = 0; burst < 8; burst++) begin
            int gap;
            int nb;
            gap = $urandom_range(0, 400);
            nb = $urandom_range(1, 6);
            for (int k = 0; k < gap; k++) step(0, 0);
            acc = 0; n = 0;
            while (acc < nb && n < 3000) begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
                if (m_accept) acc++;
                n++;
            end
        end
        drain(pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
